garota_multi: RTL and testbench

GAROTA_MULTI -- requirements
Module: garota_multi

---
 rtl/garota_multi.sv | 169 ++++++++++++++++
 tb/tb_garota_multi.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/garota_multi.sv
// ---------------------------------------------------------------------------
// garota_multi
//
// Multi-region GAROTA-style access monitor. Watches CPU data writes, DMA
// accesses, interrupt/GIE state and program-counter flow around a trusted
// code block (TCB). Any violation while running trips the monitor. Once
// tripped, it asserts a processor reset request for at least HOLD_CYCLES
// cycles and until the CPU is fetching from RESET_HANDLER.
//
// Ports
//   clk         in   system clock, rising-edge
//   puc_rst     in   asynchronous active-high reset
//   pc          in   current program counter [15:0]
//   data_en     in   CPU data access enable
//   data_wr     in   CPU data write strobe
//   data_addr   in   CPU data address [15:0]
//   dma_en      in   DMA access strobe
//   dma_addr    in   DMA address [15:0]
//   irq         in   interrupt taken
//   gie         in   global interrupt enable
//   reset       out  registered processor reset request
//   viol_cause  out  sticky cause bits [NUM_REGIONS+2:0]
//                    bit i   : protected region i
//                    bit N   : TCB atomicity (bad entry/exit)
//                    bit N+1 : interrupt or DMA while in TCB
//                    bit N+2 : GIE set while in TCB
//   viol_count  out  saturating trip counter [7:0]
// ---------------------------------------------------------------------------
module garota_multi #(
    parameter int                          NUM_REGIONS   = 4,
    parameter logic [16*NUM_REGIONS-1:0]   REGION_BASE   = {16'h0020, 16'h0130, 16'h0080, 16'hE000},
    parameter logic [16*NUM_REGIONS-1:0]   REGION_SIZE   = {16'h0006, 16'h00D0, 16'h0010, 16'h1FFF},
    parameter logic [NUM_REGIONS-1:0]      REGION_DMA    = 4'b1111,
    parameter logic [15:0]                 TCB_BASE      = 16'hFAE0,
    parameter logic [15:0]                 TCB_SIZE      = 16'h03FC,
    parameter logic [15:0]                 RESET_HANDLER = 16'h0000,
    parameter logic [7:0]                  HOLD_CYCLES   = 8'd4
) (
    input  logic                     clk,
    input  logic                     puc_rst,
    input  logic [15:0]              pc,
    input  logic                     data_en,
    input  logic                     data_wr,
    input  logic [15:0]              data_addr,
    input  logic                     dma_en,
    input  logic [15:0]              dma_addr,
    input  logic                     irq,
    input  logic                     gie,
    output logic                     reset,
    output logic [NUM_REGIONS+2:0]   viol_cause,
    output logic [7:0]               viol_count
);

    localparam logic [15:0] TCB_END = TCB_BASE + TCB_SIZE;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        TRIP = 1'b1
    } state_t;

    // Inclusive range test; the upper bound is formed in 17 bits so a region
    // reaching 16'hFFFF does not wrap around to zero.
    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] base,
                                      input logic [15:0] size);
        logic [16:0] hi;
        hi = {1'b0, base} + {1'b0, size};
        return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} <= hi);
    endfunction

    state_t                 state_q, state_d;
    logic                   reset_q, reset_d;
    logic [7:0]             hold_q, hold_d;
    logic [15:0]            prev_pc_q, prev_pc_d;
    logic [NUM_REGIONS+2:0] cause_q, cause_d;
    logic [7:0]             count_q, count_d;

    logic                   tcb_now;
    logic                   tcb_prev;
    logic [NUM_REGIONS-1:0] v_region;
    logic                   v_at;
    logic                   v_irq;
    logic                   v_gie;
    logic [NUM_REGIONS+2:0] v_all;
    logic                   viol;

    // Violation detection (purely combinational on this cycle's inputs).
    always_comb begin
        tcb_now  = in_range(pc, TCB_BASE, TCB_SIZE);
        tcb_prev = in_range(prev_pc_q, TCB_BASE, TCB_SIZE);

        v_region = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            v_region[i] =
                (data_en && data_wr && !tcb_now &&
                 in_range(data_addr, REGION_BASE[16*i +: 16], REGION_SIZE[16*i +: 16])) ||
                (REGION_DMA[i] && dma_en &&
                 in_range(dma_addr, REGION_BASE[16*i +: 16], REGION_SIZE[16*i +: 16]));
        end

        // The TCB may only be entered at its first word and left from its last.
        v_at  = (!tcb_prev && tcb_now && (pc != TCB_BASE)) ||
                (tcb_prev && !tcb_now && (prev_pc_q != TCB_END));
        v_irq = tcb_now && (irq || dma_en);
        v_gie = tcb_now && gie;

        v_all = {v_gie, v_irq, v_at, v_region};
        viol  = |v_all;
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cause_d   = cause_q;
        count_d   = count_q;
        prev_pc_d = pc;

        case (state_q)
            RUN: begin
                if (viol) begin
                    state_d = TRIP;
                    hold_d  = HOLD_CYCLES - 8'd1;
                    cause_d = cause_q | v_all;
                    count_d = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
                end
            end
            TRIP: begin
                // Violations are deliberately ignored here: the CPU is
                // already being reset.
                if (hold_q == 8'd0) begin
                    if (pc == RESET_HANDLER) begin
                        state_d = RUN;
                    end
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        reset_d = (state_d == TRIP);
    end

    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q   <= RUN;
            reset_q   <= 1'b0;
            hold_q    <= 8'd0;
            prev_pc_q <= RESET_HANDLER;
            cause_q   <= '0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            reset_q   <= reset_d;
            hold_q    <= hold_d;
            prev_pc_q <= prev_pc_d;
            cause_q   <= cause_d;
            count_q   <= count_d;
        end
    end

    assign reset      = reset_q;
    assign viol_cause = cause_q;
    assign viol_count = count_q;

endmodule

// File: tb/tb_garota_multi.sv
// ---------------------------------------------------------------------------
// tb_garota_multi
//
// Bench for garota_multi with default parameters. A behavioural model tracks
// the monitor as "tripped / cycles spent tripped" and is updated from the
// same inputs the DUT sees at each rising edge; outputs are compared one
// time unit after the edge. Directed scenarios are followed by a random run.
// ---------------------------------------------------------------------------
module tb_garota_multi;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        puc_rst;
    logic [15:0] pc;
    logic        data_en, data_wr;
    logic [15:0] data_addr;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic        irq, gie;
    logic        reset;
    logic [6:0]  viol_cause;
    logic [7:0]  viol_count;

    int total = 0;
    int bad   = 0;

    // Model state
    bit          m_trip;
    int          m_age;
    logic [15:0] m_prev_pc;
    logic [6:0]  m_cause;
    int          m_count;

    logic [15:0] r_base [4] = '{16'hE000, 16'h0080, 16'h0130, 16'h0020};
    logic [15:0] r_last [4] = '{16'hFFFF, 16'h0090, 16'h0200, 16'h0026};

    garota_multi dut (
        .clk        (clk),
        .puc_rst    (puc_rst),
        .pc         (pc),
        .data_en    (data_en),
        .data_wr    (data_wr),
        .data_addr  (data_addr),
        .dma_en     (dma_en),
        .dma_addr   (dma_addr),
        .irq        (irq),
        .gie        (gie),
        .reset      (reset),
        .viol_cause (viol_cause),
        .viol_count (viol_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit in_tcb(input logic [15:0] a);
        return (a >= 16'hFAE0) && (a <= 16'hFEDC);
    endfunction

    function automatic logic [6:0] model_viol();
        logic [6:0] v;
        bit now, prev;
        v    = '0;
        now  = in_tcb(pc);
        prev = in_tcb(m_prev_pc);
        for (int i = 0; i < 4; i++) begin
            if (data_en && data_wr && !now && data_addr >= r_base[i] && data_addr <= r_last[i])
                v[i] = 1'b1;
            if (dma_en && dma_addr >= r_base[i] && dma_addr <= r_last[i])
                v[i] = 1'b1;
        end
        if (!prev && now && pc != 16'hFAE0) v[4] = 1'b1;
        if (prev && !now && m_prev_pc != 16'hFEDC) v[4] = 1'b1;
        if (now && (irq || dma_en)) v[5] = 1'b1;
        if (now && gie) v[6] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_trip    = 1'b0;
        m_age     = 0;
        m_prev_pc = 16'h0000;
        m_cause   = '0;
        m_count   = 0;
    endtask

    task automatic model_edge();
        logic [6:0] v;
        v = model_viol();
        if (!m_trip) begin
            if (v != 0) begin
                m_trip  = 1'b1;
                m_age   = 1;
                m_cause = m_cause | v;
                if (m_count < 255) m_count++;
            end
        end else begin
            if (m_age >= HOLD && pc == 16'h0000) m_trip = 1'b0;
            else m_age++;
        end
        m_prev_pc = pc;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("reset", reset, m_trip);
        chk("cause", viol_cause, m_cause);
        chk("count", viol_count, m_count);
    endtask

    task automatic idle_inputs();
        data_en = 0; data_wr = 0; data_addr = 0;
        dma_en = 0; dma_addr = 0; irq = 0; gie = 0;
    endtask

    task automatic do_reset();
        puc_rst = 1'b1;
        #2;
        model_reset();
        chk("rst_reset", reset, 0);
        chk("rst_cause", viol_cause, 0);
        chk("rst_count", viol_count, 0);
        idle_inputs();
        pc = 16'h0000;
        puc_rst = 1'b0;
    endtask

    // Drive pc to the reset handler long enough for any hold to expire.
    task automatic leave_trip();
        idle_inputs();
        pc = 16'h0000;
        repeat (HOLD + 1) step();
    endtask

    initial begin
        int hi_cycles;
        int r;

        puc_rst = 1'b1;
        idle_inputs();
        pc = 16'h0000;
        do_reset();

        // Protected write from outside the TCB.
        pc = 16'hE100; step();
        data_en = 1; data_wr = 1; data_addr = 16'h0084; step();
        chk("w_reset", reset, 1);
        chk("w_cause", viol_cause, 7'b0000010);
        chk("w_count", viol_count, 1);
        leave_trip();

        // Same write from inside the TCB is allowed.
        do_reset();
        pc = 16'hFAE0; step();
        pc = 16'hFB00; step();
        data_en = 1; data_wr = 1; data_addr = 16'h0084; step();
        chk("tcbw_reset", reset, 0);
        chk("tcbw_cause", viol_cause, 0);
        chk("tcbw_count", viol_count, 0);
        idle_inputs();
        pc = 16'hFEDC; step();
        pc = 16'h0000; step();

        // Bad TCB entry, hold length, then a legal exit.
        do_reset();
        pc = 16'hE200; step();
        pc = 16'hFB00; step();
        chk("entry_reset", reset, 1);
        chk("entry_bit4", viol_cause[4], 1);
        hi_cycles = 1;
        pc = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            step();
            if (reset) hi_cycles++;
        end
        chk("hold_len", hi_cycles, HOLD);
        pc = 16'hFAE0; step();
        pc = 16'hFEDC; step();
        pc = 16'hE000; step();
        chk("exit_reset", reset, 0);
        chk("exit_count", viol_count, 1);

        // Simultaneous irq/gie/DMA violations inside the TCB.
        do_reset();
        pc = 16'hFAE0; step();
        pc = 16'hFB00; irq = 1; gie = 1; dma_en = 1; dma_addr = 16'hE010; step();
        chk("multi_cause", viol_cause, 7'b1100001);
        chk("multi_count", viol_count, 1);
        leave_trip();

        // Hold persists while pc is away from the handler; trip-time
        // violations are ignored.
        do_reset();
        pc = 16'hE100; data_en = 1; data_wr = 1; data_addr = 16'h0084; step();
        idle_inputs();
        pc = 16'h1234;
        repeat (20) step();
        chk("stuck_reset", reset, 1);
        data_en = 1; data_wr = 1; data_addr = 16'h0130; step();
        chk("trip_viol_count", viol_count, 1);
        chk("trip_viol_cause", viol_cause, 7'b0000010);
        idle_inputs();
        pc = 16'h0000; step();
        chk("stuck_release", reset, 0);
        step();

        // Random traffic.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: ;
                3: pc = 16'hFAE0;
                4: pc = 16'hFEDC;
                5: pc = 16'hFAE0 + 16'($urandom_range(0, 16'h03FC));
                6, 7: pc = 16'h0000;
                default: pc = 16'($urandom);
            endcase
            data_en = ($urandom_range(0, 3) == 0);
            data_wr = $urandom_range(0, 1);
            r = $urandom_range(0, 4);
            data_addr = (r < 4) ? r_base[r] + 16'($urandom_range(0, 20)) : 16'($urandom);
            dma_en = ($urandom_range(0, 9) == 0);
            dma_addr = 16'($urandom);
            irq = ($urandom_range(0, 9) == 0);
            gie = ($urandom_range(0, 9) == 0);
            step();
        end

        // Counter saturation, then asynchronous abort mid-trip.
        do_reset();
        for (int t = 0; t < 258; t++) begin
            pc = 16'hE100; data_en = 1; data_wr = 1; data_addr = 16'h0084; step();
            leave_trip();
        end
        chk("sat_count", viol_count, 8'hFF);
        pc = 16'hE100; data_en = 1; data_wr = 1; data_addr = 16'h0084; step();
        chk("sat_trip_reset", reset, 1);
        #2;
        puc_rst = 1'b1;
        #1;
        chk("abort_reset", reset, 0);
        chk("abort_cause", viol_cause, 0);
        chk("abort_count", viol_count, 0);
        model_reset();
        idle_inputs();
        pc = 16'h0000;
        #1;
        puc_rst = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
